// File: rtl/aes_mixcol_seq_wddl_if.sv
// Bus bundle for the MixColumns sequencer: state in/out handshakes, the shared
// column datapath link, and the status flags.
interface aes_mixcol_seq_wddl_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [127:0] in_p;
    logic [127:0] in_n;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_p;
    logic [127:0] out_n;
    logic [31:0]  mc_sa_p;
    logic [31:0]  mc_sa_n;
    logic [31:0]  mc_res_p;
    logic [31:0]  mc_res_n;
    logic         busy;
    logic         dr_err;

    modport slave (
        input  in_valid, in_last, in_p, in_n, out_ready, mc_res_p, mc_res_n,
        output in_ready, out_valid, out_p, out_n, mc_sa_p, mc_sa_n, busy, dr_err
    );

    modport master (
        output in_valid, in_last, in_p, in_n, out_ready, mc_res_p, mc_res_n,
        input  in_ready, out_valid, out_p, out_n, mc_sa_p, mc_sa_n, busy, dr_err
    );
endinterface

// File: rtl/aes_mixcol_seq_wddl.sv
// Time-multiplexes one dual-rail WDDL MixColumns column unit over a 128-bit AES
// state, inserting PRE_CYC precharge cycles before every column evaluation.
module aes_mixcol_seq_wddl #(
    parameter int PRE_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_mixcol_seq_wddl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PRE, EVAL, DONE} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_col;
    logic [2:0]   r_pre_cnt;
    logic [127:0] r_in_p;
    logic [127:0] r_in_n;
    logic [127:0] r_res_p;
    logic [127:0] r_res_n;
    logic [31:0]  r_sa_p;
    logic [31:0]  r_sa_n;
    logic         r_dr_err;
    logic         w_pre_done;

    assign w_pre_done = (r_pre_cnt == 3'(PRE_CYC - 1));

    function automatic logic [31:0] col_sel(input logic [127:0] s, input logic [1:0] c);
        logic [31:0] w;
        case (c)
            2'd0:    w = s[127:96];
            2'd1:    w = s[95:64];
            2'd2:    w = s[63:32];
            default: w = s[31:0];
        endcase
        return w;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_state_nxt = bus.in_last ? DONE : PRE;
            PRE:     if (w_pre_done)   w_state_nxt = EVAL;
            EVAL:    w_state_nxt = (r_col == 2'd3) ? DONE : PRE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b1;
        bus.out_valid = 1'b0;
        bus.out_p     = '0;
        bus.out_n     = '0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_p     = r_res_p;
                bus.out_n     = r_res_n;
            end
            default: ;
        endcase
    end

    assign bus.mc_sa_p = r_sa_p;
    assign bus.mc_sa_n = r_sa_n;
    assign bus.dr_err  = r_dr_err;

    // Column drive is registered off the next state so the datapath sees data
    // exactly in the EVAL cycle and both rails low everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa_p    <= '0;
            r_sa_n    <= '0;
            r_col     <= '0;
            r_pre_cnt <= '0;
            r_in_p    <= '0;
            r_in_n    <= '0;
            r_res_p   <= '0;
            r_res_n   <= '0;
            r_dr_err  <= 1'b0;
        end else begin
            r_sa_p <= '0;
            r_sa_n <= '0;
            if (w_state_nxt == EVAL) begin
                r_sa_p <= col_sel(r_in_p, r_col);
                r_sa_n <= col_sel(r_in_n, r_col);
            end
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_in_p    <= bus.in_p;
                    r_in_n    <= bus.in_n;
                    r_col     <= '0;
                    r_pre_cnt <= '0;
                    r_dr_err  <= ((bus.in_p ^ bus.in_n) != '1);
                    r_res_p   <= bus.in_last ? bus.in_p : '0;
                    r_res_n   <= bus.in_last ? bus.in_n : '0;
                end
                PRE: r_pre_cnt <= r_pre_cnt + 3'd1;
                EVAL: begin
                    r_pre_cnt <= '0;
                    case (r_col)
                        2'd0: begin r_res_p[127:96] <= bus.mc_res_p; r_res_n[127:96] <= bus.mc_res_n; end
                        2'd1: begin r_res_p[95:64]  <= bus.mc_res_p; r_res_n[95:64]  <= bus.mc_res_n; end
                        2'd2: begin r_res_p[63:32]  <= bus.mc_res_p; r_res_n[63:32]  <= bus.mc_res_n; end
                        default: begin r_res_p[31:0] <= bus.mc_res_p; r_res_n[31:0] <= bus.mc_res_n; end
                    endcase
                    if ((bus.mc_res_p ^ bus.mc_res_n) != 32'hFFFF_FFFF) r_dr_err <= 1'b1;
                    // col parks at 3 in DONE and only restarts from an accept
                    if (r_col != 2'd3) r_col <= r_col + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mixcol_seq_wddl.sv
// Bench for the MixColumns sequencer: two builds (PRE_CYC=1 and 3) share a
// behavioural column unit and a state-level MixColumns reference.
module tb_aes_mixcol_seq_wddl;
    localparam int P0 = 1;
    localparam int P1 = 3;

    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    aes_mixcol_seq_wddl_if if0();
    aes_mixcol_seq_wddl_if if1();

    logic         t_valid, t_last, t_ready, sel, fault;
    logic [127:0] t_p, t_n;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s, input logic last);
        logic [127:0] r;
        if (last) return s;
        for (int c = 0; c < 4; c++) begin
            logic [127:0] sh;
            sh = s << (32 * c);
            r = (r << 32) | {96'd0, mixcol(sh[127:96])};
        end
        return r;
    endfunction

    assign if0.in_valid  = t_valid & ~sel;
    assign if1.in_valid  = t_valid & sel;
    assign if0.in_last   = t_last;   assign if1.in_last   = t_last;
    assign if0.in_p      = t_p;      assign if1.in_p      = t_p;
    assign if0.in_n      = t_n;      assign if1.in_n      = t_n;
    assign if0.out_ready = t_ready;  assign if1.out_ready = t_ready;
    assign if0.mc_res_p  = mixcol(if0.mc_sa_p);
    assign if0.mc_res_n  = ~mixcol(~if0.mc_sa_n) ^ {26'd0, fault, 5'd0};
    assign if1.mc_res_p  = mixcol(if1.mc_sa_p);
    assign if1.mc_res_n  = ~mixcol(~if1.mc_sa_n);

    aes_mixcol_seq_wddl #(.PRE_CYC(P0)) dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));
    aes_mixcol_seq_wddl #(.PRE_CYC(P1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

    logic         m_valid, m_rdy, m_busy, m_err;
    logic [127:0] m_out_p, m_out_n;
    logic [31:0]  m_sa_p, m_sa_n;
    assign m_valid = sel ? if1.out_valid : if0.out_valid;
    assign m_rdy   = sel ? if1.in_ready  : if0.in_ready;
    assign m_busy  = sel ? if1.busy      : if0.busy;
    assign m_err   = sel ? if1.dr_err    : if0.dr_err;
    assign m_out_p = sel ? if1.out_p     : if0.out_p;
    assign m_out_n = sel ? if1.out_n     : if0.out_n;
    assign m_sa_p  = sel ? if1.mc_sa_p   : if0.mc_sa_p;
    assign m_sa_n  = sel ? if1.mc_sa_n   : if0.mc_sa_n;

    int checks = 0;
    int errors = 0;

    logic [31:0]  obs_sa_p [0:79];
    logic [31:0]  obs_sa_n [0:79];
    int           obs_k;
    logic [127:0] obs_out_p, obs_out_n;
    logic         obs_err, obs_err1;

    // Accept one state, then record per-cycle column drive until out_valid
    // (obs_k = cycles after the accepting edge, 0 if it never appeared).
    task automatic run_state(input logic [127:0] p, input logic [127:0] n,
                             input logic last, input int fault_k);
        @(negedge clk);
        t_p = p; t_n = n; t_last = last; t_valid = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0;
        obs_k = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            fault = (k == fault_k);
            obs_sa_p[k-1] = m_sa_p;
            obs_sa_n[k-1] = m_sa_n;
            if (k == 1) obs_err1 = m_err;
            if (m_valid) begin
                obs_k = k; obs_out_p = m_out_p; obs_out_n = m_out_n; obs_err = m_err;
                break;
            end
        end
        fault = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        t_valid = 1'b1; t_last = 1'b0; t_p = 128'h1; t_n = ~128'h1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if (m_rdy !== 1'b1 || m_valid !== 1'b0 || m_busy !== 1'b0 || m_err !== 1'b0 ||
                m_sa_p !== 32'd0 || m_sa_n !== 32'd0 || m_out_p !== 128'd0 || m_out_n !== 128'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d got rdy=%b vld=%b busy=%b err=%b sa=%h/%h exp 1 0 0 0 0/0",
                         s, m_rdy, m_valid, m_busy, m_err, m_sa_p, m_sa_n);
            end
        end
        sel = 1'b0;
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0; t_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_latch got busy=%b exp 0", m_busy);
        end
    endtask

    task automatic test_fips();
        logic [127:0] v, e;
        v = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        e = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        run_state(v, ~v, 1'b0, 0);
        checks++;
        if (obs_k !== 4 * (P0 + 1) + 1) begin
            errors++; $display("FAIL fips_latency got %0d exp %0d", obs_k, 4 * (P0 + 1) + 1);
        end
        checks++;
        if (obs_out_p !== e || obs_out_n !== ~e) begin
            errors++; $display("FAIL fips_out got %h/%h exp %h/%h", obs_out_p, obs_out_n, e, ~e);
        end
        checks++;
        if (obs_err !== 1'b0) begin
            errors++; $display("FAIL fips_dr_err got %b exp 0", obs_err);
        end
    endtask

    task automatic test_precharge();
        logic [127:0] v, e, sh;
        logic [31:0]  ep;
        v = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
        e = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
        run_state(v, ~v, 1'b0, 0);
        for (int k = 1; k <= obs_k; k++) begin
            logic [31:0] en;
            ep = 32'd0; en = 32'd0;
            if (k % (P0 + 1) == 0 && k <= 4 * (P0 + 1)) begin
                sh = v << (32 * (k / (P0 + 1) - 1));
                ep = sh[127:96]; en = ~sh[127:96];
            end
            checks++;
            if (obs_sa_p[k-1] !== ep || obs_sa_n[k-1] !== en) begin
                errors++;
                $display("FAIL precharge_cycle%0d got %h/%h exp %h/%h", k, obs_sa_p[k-1], obs_sa_n[k-1], ep, en);
            end
        end
        checks++;
        if (obs_out_p !== e || obs_out_n !== ~e) begin
            errors++; $display("FAIL precharge_out got %h exp %h", obs_out_p, e);
        end
    endtask

    task automatic test_bypass();
        logic [127:0] v;
        v = 128'h0123456789abcdeffedcba9876543210;
        run_state(v, ~v, 1'b1, 0);
        checks++;
        if (obs_k !== 1 || obs_out_p !== v || obs_out_n !== ~v) begin
            errors++; $display("FAIL bypass got k=%0d %h exp k=1 %h", obs_k, obs_out_p, v);
        end
        checks++;
        if (obs_sa_p[0] !== 32'd0 || obs_sa_n[0] !== 32'd0) begin
            errors++; $display("FAIL bypass_no_eval got %h/%h exp 0/0", obs_sa_p[0], obs_sa_n[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b, held;
        int seen;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        t_ready = 1'b0;
        run_state(a, ~a, 1'b0, 0);
        held = obs_out_p;
        t_p = b; t_n = ~b; t_last = 1'b0; t_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_out_p !== held || m_out_n !== ~held || m_rdy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle%0d got vld=%b rdy=%b %h exp 1 0 %h", i, m_valid, m_rdy, m_out_p, held);
            end
        end
        t_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_rdy !== 1'b1 || m_busy !== 1'b0) begin
            errors++; $display("FAIL bp_idle_gap got rdy=%b busy=%b exp 1 0", m_rdy, m_busy);
        end
        @(posedge clk);
        #1 t_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_busy !== 1'b1) begin
            errors++; $display("FAIL bp_next_accept got busy=%b exp 1", m_busy);
        end
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge clk);
            if (m_valid) begin
                seen = 1;
                checks++;
                if (m_out_p !== ref_state(b, 1'b0)) begin
                    errors++; $display("FAIL bp_second_out got %h exp %h", m_out_p, ref_state(b, 1'b0));
                end
            end
        end
        if (seen == 0) begin
            checks++; errors++; $display("FAIL bp_second_timeout got none exp out_valid");
        end
    endtask

    task automatic test_dual_rail();
        logic [127:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        run_state(v, ~v ^ 128'd1, 1'b0, 0);
        checks++;
        if (obs_err1 !== 1'b1 || obs_err !== 1'b1) begin
            errors++; $display("FAIL dr_input got %b/%b exp 1/1", obs_err1, obs_err);
        end
        run_state(v, ~v, 1'b0, 3 * (P0 + 1));
        checks++;
        if (obs_err1 !== 1'b0 || obs_err !== 1'b1) begin
            errors++; $display("FAIL dr_eval got early=%b done=%b exp 0 1", obs_err1, obs_err);
        end
        @(negedge clk);
        checks++;
        if (m_busy !== 1'b0 || m_err !== 1'b1) begin
            errors++; $display("FAIL dr_sticky got busy=%b err=%b exp 0 1", m_busy, m_err);
        end
        run_state(v, ~v, 1'b0, 0);
        checks++;
        if (obs_err1 !== 1'b0 || obs_err !== 1'b0) begin
            errors++; $display("FAIL dr_clear got %b/%b exp 0/0", obs_err1, obs_err);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic [127:0] v, e;
            logic         last;
            v = {$urandom, $urandom, $urandom, $urandom};
            last = ($urandom_range(0, 3) == 0);
            e = ref_state(v, last);
            run_state(v, ~v, last, 0);
            checks++;
            if (obs_k !== (last ? 1 : 4 * (P0 + 1) + 1) || obs_out_p !== e || obs_out_n !== ~e || obs_err !== 1'b0) begin
                errors++;
                $display("FAIL random%0d got k=%0d %h err=%b exp last=%b %h err=0", i, obs_k, obs_out_p, obs_err, last, e);
            end
        end
    endtask

    task automatic test_pre3_reset();
        logic [127:0] v, e;
        v = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        e = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        sel = 1'b1;
        @(negedge clk);
        t_p = v; t_n = ~v; t_last = 1'b0; t_valid = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0;
        repeat (2 * (P1 + 1)) @(negedge clk);
        checks++;
        if (m_sa_p !== v[95:64]) begin
            errors++; $display("FAIL pre3_col1_eval got %h exp %h", m_sa_p, v[95:64]);
        end
        rst1 = 1'b1;
        #1;
        checks++;
        if (m_rdy !== 1'b1 || m_valid !== 1'b0 || m_busy !== 1'b0 || m_err !== 1'b0 ||
            m_sa_p !== 32'd0 || m_sa_n !== 32'd0 || m_out_p !== 128'd0) begin
            errors++;
            $display("FAIL midop_reset got rdy=%b vld=%b busy=%b err=%b sa=%h exp 1 0 0 0 0", m_rdy, m_valid, m_busy, m_err, m_sa_p);
        end
        @(negedge clk);
        rst1 = 1'b0;
        run_state(v, ~v, 1'b0, 0);
        checks++;
        if (obs_k !== 4 * (P1 + 1) + 1 || obs_out_p !== e || obs_out_n !== ~e) begin
            errors++; $display("FAIL pre3_fips got k=%0d %h exp k=%0d %h", obs_k, obs_out_p, 4 * (P1 + 1) + 1, e);
        end
        sel = 1'b0;
    endtask

    initial begin
        sel = 1'b0; fault = 1'b0; t_ready = 1'b1;
        test_reset();
        test_fips();
        test_precharge();
        test_bypass();
        test_backpressure();
        test_dual_rail();
        test_random();
        test_pre3_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
